// File: rtl/pe_drain.sv
// Result drain for one systolic-array column: captures row-skewed PE results and
// serializes them in row order. Define PE_DRAIN_OUT_REG_EN for a registered 2-entry skid output.
module pe_drain #(
  parameter int D_W_ACC = 64,
  parameter int N       = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*D_W_ACC-1:0]   in_sum,
  input  logic [N-1:0]           in_valid,
  output logic [D_W_ACC-1:0]     m_data,
  output logic [$clog2(N)-1:0]   m_row,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [CNT_W-1:0]       tile_cnt,
  output logic                   ovf,
  input  logic                   ovf_clr
);

  localparam int ROW_W = $clog2(N);

  typedef enum logic {ST_WAIT, ST_SEND} state_t;

  state_t             state, state_nxt;
  logic [D_W_ACC-1:0] hold [N];
  logic [N-1:0]       hv;
  logic [N-1:0]       rel;
  logic [ROW_W-1:0]   ptr, ptr_nxt;
  logic               core_valid, core_ready, core_fire, core_last;
  logic [D_W_ACC-1:0] core_data;
  logic               ovf_set;

  always_comb begin
    core_fire = core_valid & core_ready;
    rel       = '0;
    if (core_fire) rel[ptr] = 1'b1;
    ptr_nxt   = (ptr == ROW_W'(N-1)) ? '0 : ptr + ROW_W'(1);
    ovf_set   = |(in_valid & hv & ~rel);
    core_data = hold[ptr];
    core_last = (ptr == ROW_W'(N-1));
  end

  // A row released this cycle may be refilled in the same cycle without overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hv <= '0;
      for (int unsigned r = 0; r < N; r++) hold[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < N; r++) begin
        if (in_valid[r] && (!hv[r] || rel[r])) begin
          hold[r] <= in_sum[r*D_W_ACC +: D_W_ACC];
          hv[r]   <= 1'b1;
        end else if (rel[r]) begin
          hv[r]   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_WAIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (core_fire) ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    core_valid = 1'b0;
    case (state)
      ST_WAIT: if (hv[ptr]) state_nxt = ST_SEND;
      ST_SEND: begin
        core_valid = 1'b1;
        if (core_ready) state_nxt = hv[ptr_nxt] ? ST_SEND : ST_WAIT;
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

`ifdef PE_DRAIN_OUT_REG_EN
  logic [D_W_ACC-1:0] sk_data [2];
  logic [ROW_W-1:0]   sk_row  [2];
  logic               sk_last [2];
  logic               sk_wr, sk_rd, sk_push, sk_pop;
  logic [1:0]         sk_cnt;

  // Ready toward the core depends only on registered occupancy, never on m_ready.
  assign core_ready = (sk_cnt != 2'd2);
  assign sk_push    = core_valid & core_ready;
  assign sk_pop     = (sk_cnt != 2'd0) & m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sk_cnt <= '0;
      sk_wr  <= 1'b0;
      sk_rd  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        sk_data[i] <= '0;
        sk_row[i]  <= '0;
        sk_last[i] <= 1'b0;
      end
    end else begin
      if (sk_push) begin
        sk_data[sk_wr] <= core_data;
        sk_row[sk_wr]  <= ptr;
        sk_last[sk_wr] <= core_last;
        sk_wr          <= ~sk_wr;
      end
      if (sk_pop) sk_rd <= ~sk_rd;
      sk_cnt <= sk_cnt + {1'b0, sk_push} - {1'b0, sk_pop};
    end
  end

  assign m_valid = (sk_cnt != 2'd0);
  assign m_data  = sk_data[sk_rd];
  assign m_row   = sk_row[sk_rd];
  assign m_last  = sk_last[sk_rd];
`else
  assign core_ready = m_ready;
  assign m_valid    = core_valid;
  assign m_data     = core_valid ? core_data : '0;
  assign m_row      = ptr;
  assign m_last     = core_valid & core_last;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_cnt <= '0;
    end else if (m_valid && m_ready && m_last) begin
      tile_cnt <= tile_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_drain.sv
// Directed bench for pe_drain: cycle-exact vector table plus multi-cycle scenarios
// (backpressure, overflow, release+capture, reset mid-tile).
module tb_pe_drain;
  localparam int DW = 64;
  localparam int N  = 4;
  localparam int CW = 16;
`ifdef PE_DRAIN_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] in_sum;
  logic [N-1:0]    in_valid;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_row;
  logic            m_last, m_valid, m_ready;
  logic [CW-1:0]   tile_cnt;
  logic            ovf, ovf_clr;

  always #5 clk = ~clk;

  pe_drain #(.D_W_ACC(DW), .N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_sum(in_sum), .in_valid(in_valid),
    .m_data(m_data), .m_row(m_row), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .tile_cnt(tile_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [3:0]  iv;
    logic [63:0] s0, s1, s2, s3;
    logic        ev;
    logic [63:0] ed;
    logic [1:0]  er;
    logic        el;
    logic [15:0] etc;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  r;
    logic        l;
  } beat_t;

  int    n_vec = 0;
  int    n_err = 0;
  vec_t  tbl [14];
  beat_t obs [$];

  always @(negedge clk)
    if (rst && m_valid && m_ready) obs.push_back('{m_data, m_row, m_last});

  function automatic vec_t mk(input logic [3:0] iv, input logic [63:0] s0, s1, s2, s3,
                              input logic ev, input logic [63:0] ed, input logic [1:0] er,
                              input logic el, input logic [15:0] etc);
    vec_t v;
    v.iv = iv; v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    v.ev = ev; v.ed = ed; v.er = er; v.el = el; v.etc = etc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] iv, input logic [63:0] s0, s1, s2, s3);
    in_valid = iv;
    in_sum   = {s3, s2, s1, s0};
  endtask

  task automatic expect_tile(input string name, input logic [63:0] d0, d1, d2, d3);
    logic [63:0] ed [4];
    ed = '{d0, d1, d2, d3};
    for (int k = 0; k < 200 && obs.size() < 4; k++) step();
    chk({name, " beats"}, 64'(obs.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (obs.size() > 0) begin
        beat_t b;
        b = obs.pop_front();
        chk($sformatf("%s[%0d] data", name, i), b.d, ed[i]);
        chk($sformatf("%s[%0d] row", name, i), 64'(b.r), 64'(i));
        chk($sformatf("%s[%0d] last", name, i), 64'(b.l), 64'(i == 3));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Skewed tile then simultaneous tile, m_ready held high; expectations for the unregistered build.
    tbl[0]  = mk(4'b0001, 64'h11, 0, 0, 0,   0, 0,     0, 0, 0);
    tbl[1]  = mk(4'b0010, 0, 64'h22, 0, 0,   1, 64'h11, 0, 0, 0);
    tbl[2]  = mk(4'b0100, 0, 0, 64'h33, 0,   1, 64'h22, 1, 0, 0);
    tbl[3]  = mk(4'b1000, 0, 0, 0, 64'h44,   1, 64'h33, 2, 0, 0);
    tbl[4]  = mk(4'b0000, 0, 0, 0, 0,        1, 64'h44, 3, 1, 0);
    tbl[5]  = mk(4'b0000, 0, 0, 0, 0,        0, 0,     0, 0, 1);
    tbl[6]  = mk(4'b0000, 0, 0, 0, 0,        0, 0,     0, 0, 1);
    tbl[7]  = mk(4'b1111, 5, 6, 7, 8,        0, 0,     0, 0, 1);
    tbl[8]  = mk(4'b0000, 0, 0, 0, 0,        1, 5,     0, 0, 1);
    tbl[9]  = mk(4'b0000, 0, 0, 0, 0,        1, 6,     1, 0, 1);
    tbl[10] = mk(4'b0000, 0, 0, 0, 0,        1, 7,     2, 0, 1);
    tbl[11] = mk(4'b0000, 0, 0, 0, 0,        1, 8,     3, 1, 1);
    tbl[12] = mk(4'b0000, 0, 0, 0, 0,        0, 0,     0, 0, 2);
    tbl[13] = mk(4'b0000, 0, 0, 0, 0,        0, 0,     0, 0, 2);

    rst = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    drive(4'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset m_valid", 64'(m_valid), 0);
    chk("reset m_data", m_data, 0);
    chk("reset m_row", 64'(m_row), 0);
    chk("reset m_last", 64'(m_last), 0);
    chk("reset tile_cnt", 64'(tile_cnt), 0);
    chk("reset ovf", 64'(ovf), 0);
    rst = 1'b1;

    m_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      vec_t v, e;
      v = tbl[i];
      drive(v.iv, v.s0, v.s1, v.s2, v.s3);
      step();
      e = tbl[(i >= LAT) ? i - LAT : 0];
      chk($sformatf("tbl[%0d] m_valid", i), 64'(m_valid), 64'(e.ev));
      if (e.ev) begin
        chk($sformatf("tbl[%0d] m_data", i), m_data, e.ed);
        chk($sformatf("tbl[%0d] m_row", i), 64'(m_row), 64'(e.er));
        chk($sformatf("tbl[%0d] m_last", i), 64'(m_last), 64'(e.el));
      end
      chk($sformatf("tbl[%0d] tile_cnt", i), 64'(tile_cnt), 64'(e.etc));
      chk($sformatf("tbl[%0d] ovf", i), 64'(ovf), 0);
    end
    drive(4'b0, 0, 0, 0, 0);
    obs.delete();

    // Backpressure: row 0 must sit stable on the output while m_ready is low.
    m_ready = 1'b0;
    drive(4'b0001, 64'h11, 0, 0, 0); step();
    drive(4'b0010, 0, 64'h22, 0, 0); step();
    drive(4'b0100, 0, 0, 64'h33, 0); step();
    drive(4'b1000, 0, 0, 0, 64'h44); step();
    drive(4'b0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp[%0d] m_valid", c), 64'(m_valid), 1);
      chk($sformatf("bp[%0d] m_data", c), m_data, 64'h11);
      chk($sformatf("bp[%0d] m_row", c), 64'(m_row), 0);
      step();
    end
    chk("bp no beats", 64'(obs.size()), 0);
    m_ready = 1'b1;
    expect_tile("bp", 64'h11, 64'h22, 64'h33, 64'h44);
    chk("bp ovf", 64'(ovf), 0);
    chk("bp tile_cnt", 64'(tile_cnt), 3);

    // Overflow on row 2 while rows ahead of it are empty; set beats clear.
    m_ready = 1'b0;
    drive(4'b0100, 0, 0, 64'hAA, 0); step();
    chk("ovf before", 64'(ovf), 0);
    drive(4'b0100, 0, 0, 64'hBB, 0); step();
    drive(4'b0, 0, 0, 0, 0);
    chk("ovf set", 64'(ovf), 1);
    drive(4'b0100, 0, 0, 64'hCC, 0); ovf_clr = 1'b1; step();
    drive(4'b0, 0, 0, 0, 0); ovf_clr = 1'b0;
    chk("ovf set wins", 64'(ovf), 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("ovf cleared", 64'(ovf), 0);
    drive(4'b1011, 64'h01, 64'h02, 0, 64'h04); step();
    drive(4'b0, 0, 0, 0, 0);
    m_ready = 1'b1;
    expect_tile("ovf", 64'h01, 64'h02, 64'hAA, 64'h04);
    chk("ovf tile_cnt", 64'(tile_cnt), 4);

    // Row 0 reloaded on the same edge it is released.
    drive(4'b0001, 64'h10, 0, 0, 0); step();
    drive(4'b0010, 0, 64'h20, 0, 0); step();
    drive(4'b0101, 64'h99, 0, 64'h30, 0); step();
    drive(4'b1000, 0, 0, 0, 64'h40); step();
    drive(4'b0, 0, 0, 0, 0);
    chk("rc ovf", 64'(ovf), 0);
    expect_tile("rc1", 64'h10, 64'h20, 64'h30, 64'h40);
    drive(4'b1110, 0, 64'h21, 64'h31, 64'h41); step();
    drive(4'b0, 0, 0, 0, 0);
    expect_tile("rc2", 64'h99, 64'h21, 64'h31, 64'h41);
    chk("rc tile_cnt", 64'(tile_cnt), 6);
    chk("rc ovf end", 64'(ovf), 0);

    // Asynchronous reset after two beats of a tile.
    obs.delete();
    drive(4'b1111, 64'hB0, 64'hB1, 64'hB2, 64'hB3); step();
    drive(4'b0, 0, 0, 0, 0);
    for (int k = 0; k < 50 && obs.size() < 2; k++) step();
    chk("rst pre beats", 64'(obs.size()), 2);
    if (obs.size() >= 2) begin
      chk("rst pre beat0", obs[0].d, 64'hB0);
      chk("rst pre beat1", obs[1].d, 64'hB1);
    end
    #3 rst = 1'b0;
    #1;
    chk("rst async m_valid", 64'(m_valid), 0);
    chk("rst async tile_cnt", 64'(tile_cnt), 0);
    chk("rst async m_row", 64'(m_row), 0);
    chk("rst async m_last", 64'(m_last), 0);
    #1 rst = 1'b1;
    step();
    obs.delete();
    drive(4'b1111, 64'hC0, 64'hC1, 64'hC2, 64'hC3); step();
    drive(4'b0, 0, 0, 0, 0);
    expect_tile("rst next", 64'hC0, 64'hC1, 64'hC2, 64'hC3);
    chk("rst next tile_cnt", 64'(tile_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
